// File: rtl/lsu_exec_unit.sv
// -----------------------------------------------------------------------------
// lsu_exec_unit
//
// Load/store execution stage sitting directly behind the LW/SW issue queue.
// Accepts the oldest ready memory instruction (pulsing issueblk_done so the
// queue pops its head), computes rs + imm, performs one word access on the
// data-memory port and returns load results on the CDB through a req/grant
// handshake. Stores retire silently once memory acknowledges.
//
// One instruction in flight at a time: IDLE -> ADDR -> MEM -> (CDB) -> IDLE.
//
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN - when defined, a non-word-aligned effective address
//                           sets lsu_error and skips the memory access (a load
//                           then broadcasts 0 on its tag). When undefined the
//                           low two address bits are silently dropped.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   issueque_*           head-of-queue operands, tag, opcode (1 = LW, 0 = SW)
//   issueblk_done        head accepted this cycle (only ever high in IDLE)
//   dmem_*               word-access memory port, completes on dmem_ack
//   cdb_*                result broadcast request/grant and payload
//   lsu_busy             unit is not IDLE
//   lsu_error            sticky: memory timeout (or misalignment if enabled)
// -----------------------------------------------------------------------------
module lsu_exec_unit #(
   parameter int ADDR_W      = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issueque_ready,
   input  logic [31:0]       issueque_rs_data,
   input  logic [31:0]       issueque_rt_data,
   input  logic [31:0]       issueque_imm,
   input  logic [5:0]        issueque_rd_tag,
   input  logic              issueque_opcode,
   output logic              issueblk_done,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              cdb_req,
   input  logic              cdb_grant,
   output logic [5:0]        cdb_tag_out,
   output logic [31:0]       cdb_data_out,
   output logic              cdb_valid_out,
   output logic              lsu_busy,
   output logic              lsu_error
);

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   // Counter only needs to hold 0 .. MEM_TIMEOUT-1.
   localparam int CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_MEM  = 2'd2,
      S_CDB  = 2'd3
   } state_t;

   state_t              state_q,     state_d;
   logic [DATA_W-1:0]   rs_q,        rs_d;
   logic [DATA_W-1:0]   rt_q,        rt_d;
   logic [DATA_W-1:0]   imm_q,       imm_d;
   logic [TAG_W-1:0]    tag_q,       tag_d;
   logic                is_load_q,   is_load_d;
   logic [DATA_W-1:0]   addr_q,      addr_d;
   logic [DATA_W-1:0]   load_data_q, load_data_d;
   logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;
   logic                error_q,     error_d;

   logic [DATA_W-1:0]   eff_addr;
   logic                in_mem;
   logic                in_cdb;
   logic                unused_addr_bits;

   // 32-bit wrap; carry out is discarded.
   assign eff_addr = rs_q + imm_q;

   // Low address bits only matter to the optional alignment check, and bits
   // above ADDR_W never reach the port.
   assign unused_addr_bits = ^addr_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      imm_d       = imm_q;
      tag_d       = tag_q;
      is_load_d   = is_load_q;
      addr_d      = addr_q;
      load_data_d = load_data_q;
      wait_cnt_d  = wait_cnt_q;
      error_d     = error_q;

      unique case (state_q)
         S_IDLE: begin
            if (issueque_ready) begin
               rs_d      = issueque_rs_data;
               rt_d      = issueque_rt_data;
               imm_d     = issueque_imm;
               tag_d     = issueque_rd_tag;
               is_load_d = issueque_opcode;
               state_d   = S_ADDR;
            end
         end

         S_ADDR: begin
            addr_d      = eff_addr;
            // Cleared here so that any aborted load broadcasts 0.
            load_data_d = '0;
            wait_cnt_d  = '0;
            state_d     = S_MEM;
`ifdef LSU_MISALIGN_CHECK_EN
            if (eff_addr[1:0] != 2'b00) begin
               error_d = 1'b1;
               state_d = is_load_q ? S_CDB : S_IDLE;
            end
`endif
         end

         S_MEM: begin
            if (dmem_ack) begin
               if (is_load_q) begin
                  load_data_d = dmem_rdata;
                  state_d     = S_CDB;
               end else begin
                  state_d     = S_IDLE;
               end
            end else if (wait_cnt_q == CNT_LAST) begin
               // Abort; a load still broadcasts (data 0) so dependants wake.
               error_d = 1'b1;
               state_d = is_load_q ? S_CDB : S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         S_CDB: begin
            if (cdb_grant) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rs_q        <= '0;
         rt_q        <= '0;
         imm_q       <= '0;
         tag_q       <= '0;
         is_load_q   <= 1'b0;
         addr_q      <= '0;
         load_data_q <= '0;
         wait_cnt_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         imm_q       <= imm_d;
         tag_q       <= tag_d;
         is_load_q   <= is_load_d;
         addr_q      <= addr_d;
         load_data_q <= load_data_d;
         wait_cnt_q  <= wait_cnt_d;
         error_q     <= error_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: decoded from registered state only, except the two handshake
   // replies (issueblk_done, cdb_valid_out) which must answer in-cycle.
   // --------------------------------------------------------------------------
   assign in_mem = (state_q == S_MEM);
   assign in_cdb = (state_q == S_CDB);

   // Gated with reset so nothing is asserted while reset is held.
   assign issueblk_done = reset & (state_q == S_IDLE) & issueque_ready;

   assign dmem_req      = in_mem;
   assign dmem_we       = in_mem & ~is_load_q;
   assign dmem_addr     = in_mem ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign dmem_wdata    = in_mem ? rt_q : '0;

   assign cdb_req       = in_cdb;
   assign cdb_tag_out   = in_cdb ? tag_q : '0;
   assign cdb_data_out  = in_cdb ? load_data_q : '0;
   assign cdb_valid_out = in_cdb & cdb_grant;

   assign lsu_busy      = (state_q != S_IDLE);
   assign lsu_error     = error_q;

endmodule

// File: tb/tb_lsu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_lsu_exec_unit
//
// Directed bench for lsu_exec_unit with hand-computed expectations. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the falling
// edge. Every comparison goes through check_eq.
// -----------------------------------------------------------------------------
module tb_lsu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        issueque_ready;
   logic [31:0] issueque_rs_data;
   logic [31:0] issueque_rt_data;
   logic [31:0] issueque_imm;
   logic [5:0]  issueque_rd_tag;
   logic        issueque_opcode;
   logic        issueblk_done;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        cdb_req;
   logic        cdb_grant;
   logic [5:0]  cdb_tag_out;
   logic [31:0] cdb_data_out;
   logic        cdb_valid_out;
   logic        lsu_busy;
   logic        lsu_error;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   lsu_exec_unit #(
      .ADDR_W      (32),
      .MEM_TIMEOUT (15)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .issueque_ready   (issueque_ready),
      .issueque_rs_data (issueque_rs_data),
      .issueque_rt_data (issueque_rt_data),
      .issueque_imm     (issueque_imm),
      .issueque_rd_tag  (issueque_rd_tag),
      .issueque_opcode  (issueque_opcode),
      .issueblk_done    (issueblk_done),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack),
      .cdb_req          (cdb_req),
      .cdb_grant        (cdb_grant),
      .cdb_tag_out      (cdb_tag_out),
      .cdb_data_out     (cdb_data_out),
      .cdb_valid_out    (cdb_valid_out),
      .lsu_busy         (lsu_busy),
      .lsu_error        (lsu_error)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] rs, input logic [31:0] imm,
                        input logic [31:0] rt, input logic [5:0] tag,
                        input logic op);
      issueque_ready   = 1'b1;
      issueque_rs_data = rs;
      issueque_imm     = imm;
      issueque_rt_data = rt;
      issueque_rd_tag  = tag;
      issueque_opcode  = op;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b0;
      issueque_ready   = 1'b0;
      issueque_rs_data = '0;
      issueque_rt_data = '0;
      issueque_imm     = '0;
      issueque_rd_tag  = '0;
      issueque_opcode  = 1'b0;
      dmem_rdata       = '0;
      dmem_ack         = 1'b0;
      cdb_grant        = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rst_busy",  lsu_busy,  0);
      check_eq("rst_req",   dmem_req,  0);
      check_eq("rst_cdb",   cdb_req,   0);
      check_eq("rst_err",   lsu_error, 0);
      check_eq("rst_addr",  dmem_addr, 0);
      issueque_ready = 1'b1;
      #1;
      check_eq("rst_done_gated", issueblk_done, 0);
      issueque_ready = 1'b0;
      cyc();
      reset = 1'b1;

      // ---------------- LW, immediate ack and grant ----------------
      cyc();
      issue(32'h100, 32'h8, 32'hAAAA, 6'd5, 1'b1);
      @(negedge clk);
      check_eq("lw_done",      issueblk_done, 1);
      check_eq("lw_busy_acc",  lsu_busy,      0);
      cyc();
      issueque_ready = 1'b0;
      issueque_rs_data = '0;
      issueque_imm     = '0;
      @(negedge clk);
      check_eq("lw_done_addr", issueblk_done, 0);
      check_eq("lw_busy_addr", lsu_busy,      1);
      check_eq("lw_req_addr",  dmem_req,      0);
      cyc();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check_eq("lw_req",  dmem_req,  1);
      check_eq("lw_we",   dmem_we,   0);
      check_eq("lw_addr", dmem_addr, 32'h108);
      cyc();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      cdb_grant  = 1'b1;
      @(negedge clk);
      check_eq("lw_cdb_req",   cdb_req,       1);
      check_eq("lw_cdb_valid", cdb_valid_out, 1);
      check_eq("lw_cdb_tag",   cdb_tag_out,   5);
      check_eq("lw_cdb_data",  cdb_data_out,  32'hDEADBEEF);
      check_eq("lw_mem_off",   dmem_req,      0);
      cyc();
      dmem_ack = 1'b1;  // stray ack/grant while idle must be ignored
      @(negedge clk);
      check_eq("lw_idle_busy",  lsu_busy,      0);
      check_eq("lw_idle_valid", cdb_valid_out, 0);
      check_eq("lw_idle_cdb",   cdb_req,       0);
      cyc();
      dmem_ack  = 1'b0;
      cdb_grant = 1'b0;
      @(negedge clk);
      check_eq("stray_busy", lsu_busy, 0);

      // ---------------- SW, negative offset ----------------
      cyc();
      issue(32'h200, 32'hFFFF_FFFC, 32'h1234, 6'd3, 1'b0);
      @(negedge clk);
      check_eq("sw_done", issueblk_done, 1);
      cyc();
      issueque_ready = 1'b0;
      cyc();
      dmem_ack = 1'b1;
      @(negedge clk);
      check_eq("sw_req",   dmem_req,   1);
      check_eq("sw_we",    dmem_we,    1);
      check_eq("sw_addr",  dmem_addr,  32'h1FC);
      check_eq("sw_wdata", dmem_wdata, 32'h1234);
      check_eq("sw_nocdb", cdb_req,    0);
      cyc();
      dmem_ack = 1'b0;
      @(negedge clk);
      check_eq("sw_busy_end", lsu_busy, 0);
      check_eq("sw_nocdb2",   cdb_req,  0);
      check_eq("sw_req_end",  dmem_req, 0);

      // ---------------- LW with wait states, ready held high ----------------
      cyc();
      issue(32'h40, 32'h10, 32'h0, 6'd9, 1'b1);
      @(negedge clk);
      check_eq("ws_done", issueblk_done, 1);
      cyc();
      @(negedge clk);
      check_eq("ws_done_addr", issueblk_done, 0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("ws_mem_req",  dmem_req,      1);
         check_eq("ws_mem_addr", dmem_addr,     32'h50);
         check_eq("ws_mem_done", issueblk_done, 0);
         cyc();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check_eq("ws_ack_req", dmem_req, 1);
      cyc();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("ws_cdb_req",   cdb_req,       1);
         check_eq("ws_cdb_tag",   cdb_tag_out,   9);
         check_eq("ws_cdb_data",  cdb_data_out,  32'hCAFEF00D);
         check_eq("ws_cdb_valid", cdb_valid_out, 0);
         check_eq("ws_cdb_done",  issueblk_done, 0);
         check_eq("ws_cdb_mreq",  dmem_req,      0);
         cyc();
      end
      cdb_grant      = 1'b1;
      issueque_ready = 1'b0;
      @(negedge clk);
      check_eq("ws_valid", cdb_valid_out, 1);
      check_eq("ws_data",  cdb_data_out,  32'hCAFEF00D);
      cyc();
      cdb_grant = 1'b0;
      @(negedge clk);
      check_eq("ws_busy_end", lsu_busy, 0);

      // ---------------- LW timeout ----------------
      cyc();
      issue(32'h300, 32'h0, 32'h0, 6'h2A, 1'b1);
      cyc();
      issueque_ready = 1'b0;
      cyc();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check_eq("to_req", dmem_req,  1);
         check_eq("to_err", lsu_error, 0);
         cyc();
      end
      cdb_grant = 1'b1;
      @(negedge clk);
      check_eq("to_req_off", dmem_req,      0);
      check_eq("to_cdb_req", cdb_req,       1);
      check_eq("to_tag",     cdb_tag_out,   6'h2A);
      check_eq("to_data",    cdb_data_out,  0);
      check_eq("to_valid",   cdb_valid_out, 1);
      check_eq("to_err_set", lsu_error,     1);
      cyc();
      cdb_grant = 1'b0;
      @(negedge clk);
      check_eq("to_busy_end", lsu_busy,  0);
      check_eq("to_sticky",   lsu_error, 1);

      // ---------------- reset during MEM ----------------
      cyc();
      issue(32'h500, 32'h0, 32'h0, 6'd7, 1'b1);
      cyc();
      issueque_ready = 1'b0;
      cyc();
      @(negedge clk);
      check_eq("rm_req_before", dmem_req, 1);
      #1;
      reset = 1'b0;
      #1;
      check_eq("rm_req",  dmem_req,  0);
      check_eq("rm_busy", lsu_busy,  0);
      check_eq("rm_err",  lsu_error, 0);
      check_eq("rm_addr", dmem_addr, 0);
      check_eq("rm_cdb",  cdb_req,   0);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      check_eq("rm_post_busy", lsu_busy, 0);
      check_eq("rm_post_cdb",  cdb_req,  0);
      cyc();
      issue(32'h600, 32'h20, 32'h77, 6'd1, 1'b0);
      @(negedge clk);
      check_eq("rm_sw_done", issueblk_done, 1);
      cyc();
      issueque_ready = 1'b0;
      cyc();
      dmem_ack = 1'b1;
      @(negedge clk);
      check_eq("rm_sw_req",   dmem_req,   1);
      check_eq("rm_sw_we",    dmem_we,    1);
      check_eq("rm_sw_addr",  dmem_addr,  32'h620);
      check_eq("rm_sw_wdata", dmem_wdata, 32'h77);
      cyc();
      dmem_ack = 1'b0;
      @(negedge clk);
      check_eq("rm_sw_busy", lsu_busy, 0);
      check_eq("rm_sw_cdb",  cdb_req,  0);

      // ---------------- misaligned LW ----------------
      cyc();
      issue(32'h102, 32'h0, 32'h0, 6'h11, 1'b1);
      cyc();
      issueque_ready = 1'b0;
      cyc();
`ifdef LSU_MISALIGN_CHECK_EN
      cdb_grant = 1'b1;
      @(negedge clk);
      check_eq("ma_req",   dmem_req,      0);
      check_eq("ma_cdb",   cdb_req,       1);
      check_eq("ma_err",   lsu_error,     1);
      check_eq("ma_tag",   cdb_tag_out,   6'h11);
      check_eq("ma_data",  cdb_data_out,  0);
      check_eq("ma_valid", cdb_valid_out, 1);
      cyc();
      cdb_grant = 1'b0;
`else
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h5555AAAA;
      @(negedge clk);
      check_eq("ma_req",  dmem_req,  1);
      check_eq("ma_addr", dmem_addr, 32'h100);
      check_eq("ma_err",  lsu_error, 0);
      cyc();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      cdb_grant  = 1'b1;
      @(negedge clk);
      check_eq("ma_valid", cdb_valid_out, 1);
      check_eq("ma_tag",   cdb_tag_out,   6'h11);
      check_eq("ma_data",  cdb_data_out,  32'h5555AAAA);
      cyc();
      cdb_grant = 1'b0;
`endif
      @(negedge clk);
      check_eq("ma_busy_end", lsu_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
